// File: rtl/mdu_seq_div.sv
// Restoring radix-2 sequential divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro MDU_DIV_EARLY_EXIT_EN: short-circuit |rs1| < |rs2| in PREP (same results, lower latency).
module mdu_seq_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      function3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] mdu_result,
    output logic            busy
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            signed_op, a_neg, b_neg, special;
    logic [XLEN-1:0] abs_a, abs_b, q_fix, r_fix;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        special  = 1'b0;

        signed_op = ~f3_q[0];
        a_neg     = signed_op & op_a_q[XLEN-1];
        b_neg     = signed_op & op_b_q[XLEN-1];
        abs_a     = a_neg ? -op_a_q : op_a_q;
        abs_b     = b_neg ? -op_b_q : op_b_q;

        // op_b_q holds the divisor magnitude during ITER; quo_q shifts the dividend out as quotient bits enter
        shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        trial   = {1'b0, shifted} - {2'b00, op_b_q};
        q_fix   = qneg_q ? -quo_q : quo_q;
        r_fix   = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    f3_d    = function3;
                    op_a_d  = rs1;
                    op_b_d  = rs2;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                state_d = S_ITER;
                cnt_d   = '0;
                rem_d   = '0;
                quo_d   = abs_a;
                op_b_d  = abs_b;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                if (!f3_q[2]) begin
                    special = 1'b1;
                    quo_d   = '0;
                    rem_d   = '0;
                end else if (op_b_q == '0) begin
                    special = 1'b1;
                    quo_d   = '1;
                    rem_d   = {1'b0, op_a_q};
                end else if (signed_op && op_a_q == MIN_NEG && op_b_q == '1) begin
                    special = 1'b1;
                    quo_d   = MIN_NEG;
                    rem_d   = '0;
                end
`ifdef MDU_DIV_EARLY_EXIT_EN
                else if (abs_a < abs_b) begin
                    special = 1'b1;
                    quo_d   = '0;
                    rem_d   = {1'b0, op_a_q};
                end
`endif
                // Preset results are already in final signed form, so FIX must not negate them
                if (special) begin
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                    state_d = S_FIX;
                end
            end
            S_ITER: begin
                rem_d = trial[XLEN+1] ? shifted : trial[XLEN:0];
                quo_d = {quo_q[XLEN-2:0], ~trial[XLEN+1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = f3_q[1] ? r_fix : q_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign mdu_result = result_q;

endmodule

// File: tb/tb_mdu_seq_div.sv
// Self-checking bench for mdu_seq_div: directed cases, backpressure, flush, async reset, random ops vs arithmetic model.
module tb_mdu_seq_div;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  function3 = 3'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] mdu_result;
    logic        busy;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    mdu_seq_div #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .function3(function3), .rs1(rs1), .rs2(rs2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .mdu_result(mdu_result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V division semantics via 64-bit truncating arithmetic (covers signed overflow naturally)
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (!f[2]) return 32'd0;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        sa = f[0] ? longint'(a) : longint'($signed(a));
        sb = f[0] ? longint'(b) : longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return f[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_DIV_EARLY_EXIT_EN
        longint ma, mb;
`endif
        if (!f[2] || b == 32'd0) return 2;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MDU_DIV_EARLY_EXIT_EN
        ma = f[0] ? longint'(a) : longint'($signed(a));
        mb = f[0] ? longint'(b) : longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (ma < mb) return 2;
`endif
        return 34;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        function3 = f; rs1 = a; rs2 = b; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (resp_valid) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res);
        int lat;
        issue(f, a, b);
        wait_resp(lat);
        chk({tag, "_result"}, mdu_result, exp_res);
        chk({tag, "_latency"}, lat, model_lat(f, a, b));
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        logic [2:0]  f;
        logic [31:0] a, b;

        #12;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_result", mdu_result, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14);
        chk("divu_normal_latency_const", model_lat(F_DIVU, 32'd100, 32'd7), 32'd34);
        run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2);
        run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("rem_7_m2", F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
        run_op("div_5_0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_5_0", F_REMU, 32'd5, 32'd0, 32'd5);
        run_op("rem_m5_0", F_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("divu_3_10", F_DIVU, 32'd3, 32'd10, 32'd0);
        run_op("remu_3_10", F_REMU, 32'd3, 32'd10, 32'd3);
        run_op("rem_m3_10", F_REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD);
        run_op("mul_code", 3'b001, 32'd6, 32'd7, 32'd0);

        // Backpressure: result must hold while resp_ready is low
        issue(F_DIVU, 32'd1000, 32'd3);
        wait_resp(lat);
        chk("bp_latency", lat, 32'd34);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_result", mdu_result, 32'd333);
            chk("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
            chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        function3 = F_DIVU; rs1 = 32'd50; rs2 = 32'd5; req_valid = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0; req_valid = 1'b0;
        chk("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
        chk("bp_not_accepted", {31'd0, busy}, 32'd0);
        chk("bp_resp_dropped", {31'd0, resp_valid}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (resp_valid || busy) seen = 1;
        end
        chk("bp_no_stray_op", seen, 32'd0);

        // Flush at ITER count 10: the accept edge enters PREP, 11 more edges reach count 10
        issue(F_DIVU, 32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        chk("flush_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
        chk("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (resp_valid) seen = 1;
        end
        chk("flush_no_resp", seen, 32'd0);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        run_op("after_idle_flush", F_DIVU, 32'd1000, 32'd3, 32'd333);

        // Asynchronous reset mid-ITER
        issue(F_DIVU, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_result", mdu_result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_op("after_arst", F_DIVU, 32'd1000, 32'd3, 32'd333);

        for (int n = 0; n < 60; n++) begin
            f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op("random", f, a, b, model(f, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
